adder_seq_ctrl: RTL and testbench
=================================

Name: adder_seq_ctrl

Overview:
Multi-cycle sequencer that computes a WIDTH-bit add by time-multiplexing one 4-bit carry-lookahead nibble adder slice, LSB nibble first. The carry is chained between nibbles through a register.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades area for latency when a full-width CLA is too large.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NIB (localparam), WIDTH/4, nibble-iteration count
CW (localparam), max(1, clog2(NIB)), nibble-counter width

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
io_in_valid  in  1  operand request valid
io_in_ready  out  1  block can accept operands
io_a  in  WIDTH  operand A
io_b  in  WIDTH  operand B
io_cIn  in  1  carry into nibble 0
io_out_valid  out  1  result valid
io_out_ready  in  1  consumer accepts result
io_s  out  WIDTH  sum
io_cOut  out  1  carry out of the top nibble
io_busy  out  1  high in RUN or DONE

Behaviour:
- Reset: clock edge with reset=0 → state IDLE; io_out_valid=0, io_s=0, io_cOut=0, io_busy=0, counter=0, carry reg=0, operand regs=0. io_in_ready=1 the cycle after reset releases.
- States and transitions:
  - IDLE: io_in_ready=1. On io_in_valid&&io_in_ready: latch a, b, cIn into registers; clear the sum register; counter=0; go to RUN.
  - RUN: io_in_ready=0. Each cycle, drive the slice with a[4k+3:4k], b[4k+3:4k] and the carry reg, where k=counter.
    - Write the slice sum into s[4k+3:4k]; carry reg ← slice cOut.
    - If k==NIB-1, go to DONE; else counter+1.
  - DONE: io_out_valid=1; io_s and io_cOut are held stable. On io_out_ready, go to IDLE and drop io_out_valid the next cycle.
- Latency: accept at edge t. io_out_valid rises after edge t+NIB. Minimum initiation interval is NIB+2 cycles; the block does not overlap a new accept with DONE.
- Arithmetic: io_s = (a+b+cIn) mod 2^WIDTH; io_cOut = bit WIDTH of that sum. Internal carry is exactly 1 bit; no wider accumulation.
- io_in_valid during RUN/DONE is ignored. The operand registers are not disturbed, and the producer must hold its request until io_in_ready.
- io_out_ready while not in DONE has no effect.
- WIDTH=4 (NIB=1): RUN lasts one cycle; the counter is tied to 0.
- Reset asserted mid-RUN or in DONE: the next edge returns to IDLE with the reset values above. The partial result is discarded and never presented.
- io_s/io_cOut hold their last result in IDLE until the next accept clears the sum register.

Optional Feature:
Macro ADDER_SEQ_SUB_EN.
- Defined:
  - Adds input port io_sub (1 bit), latched at accept.
  - When io_sub=1, the block latches ~io_b and forces cIn=1 (io_cIn is ignored), so io_s = a-b mod 2^WIDTH.
  - io_cOut=1 means no borrow.
- Undefined: the port is absent and the block is add-only; behaviour is identical to io_sub=0.

Decomposition:
- Shared package adder_pkg: NIBBLE_W=4 constant; state enum typedef (IDLE, RUN, DONE); function nib_count(width).
- One sub-module: the existing 4-bit CLA nibble adder (PG generation plus carry generation), instantiated once and driven combinationally from the muxed nibble and carry reg.
- The controller FSM, counter and registers stay in adder_seq_ctrl.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cIn=0, out_ready=1 → after 4 RUN cycles: io_s=0x5555, io_cOut=0; io_out_valid high exactly 1 cycle; in_ready low for 5 cycles.
- a=0xFFFF, b=0x0001, cIn=0 → io_s=0x0000, io_cOut=1 (carry ripples through every nibble); also a=0xFFFF, b=0x0000, cIn=1 → io_s=0x0000, io_cOut=1.
- Backpressure: a=0x00F0, b=0x0010, out_ready=0 for 3 cycles in DONE → io_out_valid, io_s=0x0100, io_cOut=0 held stable; IDLE one cycle after out_ready=1. A second request asserted during DONE is accepted only after that.
- Reset=0 during the 2nd RUN cycle of a=0xABCD, b=0x1111 → next cycle: IDLE, io_out_valid=0, io_s=0, io_busy=0; no result ever emitted. The next request 0x0001+0x0001 → io_s=0x0002.
- WIDTH=4 build: a=0x9, b=0x8, cIn=1 → io_s=0x2, io_cOut=1 after 1 RUN cycle.
- ADDER_SEQ_SUB_EN: a=0x0005, b=0x0007, io_sub=1 → io_s=0xFFFE, io_cOut=0; a=0x0007, b=0x0005 → io_s=0x0002, io_cOut=1.

Source files
------------

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : adder_pkg
//  Purpose : Shared definitions for the nibble-serial adder sequencer:
//            nibble width, controller state encoding and a nibble-count helper.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of nibble iterations needed for a given operand width.
   function automatic int nib_count(input int width);
      return width / NIBBLE_W;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adder_seq_ctrl_cla4.sv
`default_nettype none
// ============================================================================
//  Module  : adder_seq_ctrl_cla4
//  Purpose : 4-bit carry-lookahead nibble adder (propagate/generate terms and
//            a flat lookahead carry network). Purely combinational.
//  Ports   : i_a, i_b [3:0]  nibble operands
//            i_cIn           carry into bit 0
//            o_sum [3:0]     nibble sum
//            o_cOut          carry out of bit 3
//  Rev     : 1.0  initial release
// ============================================================================
module adder_seq_ctrl_cla4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cIn,
   output logic [3:0] o_sum,
   output logic       o_cOut
);

   logic [3:0] w_p;
   logic [3:0] w_g;
   logic [4:0] w_c;

   assign w_p = i_a ^ i_b;
   assign w_g = i_a & i_b;

   // Every carry is expanded directly from the nibble carry-in so no carry
   // ripples through a previous carry term.
   assign w_c[0] = i_cIn;
   assign w_c[1] = w_g[0] | (w_p[0] & i_cIn);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cIn);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & i_cIn);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cIn);

   assign o_sum  = w_p ^ w_c[3:0];
   assign o_cOut = w_c[4];

endmodule
`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : adder_seq_ctrl
//  Purpose : Multi-cycle WIDTH-bit adder that reuses a single 4-bit CLA slice,
//            LSB nibble first, chaining the carry through a register.
//  Ports   : clock, reset (sync, active-low)
//            io_in_valid/io_in_ready, io_a, io_b, io_cIn   operand side
//            io_out_valid/io_out_ready, io_s, io_cOut      result side
//            io_busy                                        high in RUN/DONE
//            io_sub   (only with ADDER_SEQ_SUB_EN) 1 = compute a-b
//  Macro   : ADDER_SEQ_SUB_EN enables the subtract input.
//  Rev     : 1.0  initial release
// ============================================================================
module adder_seq_ctrl
   import adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
`ifdef ADDER_SEQ_SUB_EN
   input  logic             io_sub,
`endif
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_a,
   input  logic [WIDTH-1:0] io_b,
   input  logic             io_cIn,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_s,
   output logic             io_cOut,
   output logic             io_busy
);

   localparam int NIB = nib_count(WIDTH);
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] c_lastNib = CW'(NIB - 1);

   generate
      if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_badWidth
         $error("adder_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   state_t           r_state;
   state_t           w_nextState;
   logic             w_accept;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_s;
   logic             r_carry;
   logic             r_cOut;
   logic [CW-1:0]    w_count;
   logic             w_lastNib;
   logic [CW+1:0]    w_base;
   logic [WIDTH-1:0] w_bIn;
   logic             w_cIn;
   logic [3:0]       w_nibSum;
   logic             w_nibCout;

   // Subtraction is a + ~b + 1, so it only changes what gets latched.
`ifdef ADDER_SEQ_SUB_EN
   assign w_bIn = io_sub ? ~io_b : io_b;
   assign w_cIn = io_sub ? 1'b1  : io_cIn;
`else
   assign w_bIn = io_b;
   assign w_cIn = io_cIn;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState  = r_state;
      w_accept     = 1'b0;
      io_in_ready  = 1'b0;
      io_out_valid = 1'b0;
      io_busy      = 1'b0;
      case (r_state)
         IDLE: begin
            io_in_ready = 1'b1;
            if (io_in_valid) begin
               w_accept    = 1'b1;
               w_nextState = RUN;
            end
         end
         RUN: begin
            io_busy = 1'b1;
            if (w_lastNib) w_nextState = DONE;
         end
         DONE: begin
            io_busy      = 1'b1;
            io_out_valid = 1'b1;
            if (io_out_ready) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // ------------------------------------------------------- nibble counter
   generate
      if (NIB > 1) begin : g_counter
         logic [CW-1:0] r_count;
         always_ff @(posedge clock) begin
            if (!reset)                       r_count <= '0;
            else if (w_accept)                r_count <= '0;
            else if (r_state == RUN && !w_lastNib) r_count <= r_count + 1'b1;
         end
         assign w_count = r_count;
      end else begin : g_noCounter
         // A single nibble needs no iteration index.
         assign w_count = '0;
      end
   endgenerate

   assign w_lastNib = (w_count == c_lastNib);
   assign w_base    = {w_count, 2'b00};

   // ------------------------------------------------------------- datapath
   adder_seq_ctrl_cla4 u_cla4 (
      .i_a    (r_a[w_base +: NIBBLE_W]),
      .i_b    (r_b[w_base +: NIBBLE_W]),
      .i_cIn  (r_carry),
      .o_sum  (w_nibSum),
      .o_cOut (w_nibCout)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_cOut  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= io_a;
         r_b     <= w_bIn;
         r_carry <= w_cIn;
         r_s     <= '0;
      end else if (r_state == RUN) begin
         r_s[w_base +: NIBBLE_W] <= w_nibSum;
         r_carry                 <= w_nibCout;
         // Result carry is kept apart from the chain carry so io_cOut stays
         // at the last result until the next one completes.
         if (w_lastNib) r_cOut <= w_nibCout;
      end
   end

   assign io_s    = r_s;
   assign io_cOut = r_cOut;

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_adder_seq_ctrl
//  Purpose : Self-checking bench for adder_seq_ctrl (WIDTH=16 and WIDTH=4
//            instances) against an arithmetic reference model.
//  Macro   : ADDER_SEQ_SUB_EN adds subtract stimulus.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_adder_seq_ctrl;

`ifdef ADDER_SEQ_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   always #5 clock = ~clock;

   // WIDTH=16 instance
   logic        inValid16 = 1'b0, inReady16, outValid16, outReady16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0, s16;
   logic        cIn16 = 1'b0, cOut16, busy16, sub16 = 1'b0;

   // WIDTH=4 instance
   logic        inValid4 = 1'b0, inReady4, outValid4, outReady4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0, s4;
   logic        cIn4 = 1'b0, cOut4, busy4, sub4 = 1'b0;

   int passCount  = 0;
   int failCount  = 0;
   int checkCount = 0;

   adder_seq_ctrl #(.WIDTH(16)) dut16 (
`ifdef ADDER_SEQ_SUB_EN
      .io_sub       (sub16),
`endif
      .clock        (clock),
      .reset        (reset),
      .io_in_valid  (inValid16),
      .io_in_ready  (inReady16),
      .io_a         (a16),
      .io_b         (b16),
      .io_cIn       (cIn16),
      .io_out_valid (outValid16),
      .io_out_ready (outReady16),
      .io_s         (s16),
      .io_cOut      (cOut16),
      .io_busy      (busy16)
   );

   adder_seq_ctrl #(.WIDTH(4)) dut4 (
`ifdef ADDER_SEQ_SUB_EN
      .io_sub       (sub4),
`endif
      .clock        (clock),
      .reset        (reset),
      .io_in_valid  (inValid4),
      .io_in_ready  (inReady4),
      .io_a         (a4),
      .io_b         (b4),
      .io_cIn       (cIn4),
      .io_out_valid (outValid4),
      .io_out_ready (outReady4),
      .io_s         (s4),
      .io_cOut      (cOut4),
      .io_busy      (busy4)
   );

   // Reference: (a + b + cIn) over w bits, or a - b as a + ~b + 1.
   function automatic logic [32:0] refAdd(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin,
                                          input logic sub);
      logic [32:0] m;
      logic [32:0] bb;
      m  = (33'd1 << w) - 33'd1;
      bb = sub ? ({1'b0, ~b} & m) : ({1'b0, b} & m);
      return ({1'b0, a} & m) + bb + (sub ? 33'd1 : {32'd0, cin});
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One transaction on the 16-bit instance. holdCycles>0 keeps out_ready low
   // in DONE and meanwhile presents a competing request that must not be taken.
   task automatic doOp16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input int holdCycles, input string tag);
      logic [32:0] r;
      logic [15:0] expS;
      logic        expC;
      int          n;
      r    = refAdd(16, {16'd0, a}, {16'd0, b}, cin, sub);
      expS = r[15:0];
      expC = r[16];
      a16 = a; b16 = b; cIn16 = cin; sub16 = sub;
      inValid16  = 1'b1;
      outReady16 = (holdCycles == 0);
      n = 0;
      while (!inReady16 && n < 20) begin tick(); n++; end
      check({tag, "_inReady"}, {31'd0, inReady16}, 32'd1);
      tick();                                   // accept edge
      inValid16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); cIn16 = 1'($urandom);
      check({tag, "_runBusy"}, {30'd0, inReady16, busy16}, 32'd1);
      n = 0;
      while (!outValid16 && n < 40) begin tick(); n++; end
      check({tag, "_latency"}, n, 32'd4);
      check({tag, "_s"}, {16'd0, s16}, {16'd0, expS});
      check({tag, "_cOut"}, {31'd0, cOut16}, {31'd0, expC});
      if (holdCycles > 0) begin
         inValid16 = 1'b1;
         for (int i = 0; i < holdCycles; i++) begin
            tick();
            check({tag, "_holdValid"}, {30'd0, outValid16, inReady16}, 32'd2);
            check({tag, "_holdS"}, {15'd0, cOut16, s16}, {15'd0, expC, expS});
         end
         outReady16 = 1'b1;
      end
      tick();
      // Back in IDLE: result still held, nothing accepted during DONE.
      check({tag, "_idle"}, {29'd0, outValid16, inReady16, busy16}, 32'd2);
      check({tag, "_idleS"}, {15'd0, cOut16, s16}, {15'd0, expC, expS});
      outReady16 = 1'b0;
      inValid16  = 1'b0;
   endtask

   task automatic doOp4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic sub, input string tag);
      logic [32:0] r;
      int          n;
      r = refAdd(4, {28'd0, a}, {28'd0, b}, cin, sub);
      a4 = a; b4 = b; cIn4 = cin; sub4 = sub;
      inValid4  = 1'b1;
      outReady4 = 1'b1;
      n = 0;
      while (!inReady4 && n < 20) begin tick(); n++; end
      tick();
      inValid4 = 1'b0;
      n = 0;
      while (!outValid4 && n < 20) begin tick(); n++; end
      check({tag, "_latency4"}, n, 32'd1);
      check({tag, "_sum4"}, {27'd0, cOut4, s4}, {27'd0, r[4:0]});
      tick();
      check({tag, "_idle4"}, {30'd0, outValid4, inReady4}, 32'd1);
      outReady4 = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) tick();
      check("rst_outputs16", {13'd0, outValid16, busy16, cOut16, s16}, 32'd0);
      check("rst_outputs4", {25'd0, outValid4, busy4, cOut4, s4}, 32'd0);
      reset = 1'b1;
      tick();
      check("rst_inReady", {30'd0, inReady16, inReady4}, 32'd3);

      // Directed transactions
      doOp16(16'h1234, 16'h4321, 1'b0, 1'b0, 0, "basic");
      doOp16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "ripple");
      doOp16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, "cinRipple");
      doOp16(16'h00F0, 16'h0010, 1'b0, 1'b0, 3, "backpressure");
      doOp16(16'h8000, 16'h8000, 1'b0, 1'b0, 0, "topCarry");

      // Reset in the second RUN cycle discards the partial result
      a16 = 16'hABCD; b16 = 16'h1111; cIn16 = 1'b0; sub16 = 1'b0;
      inValid16 = 1'b1; outReady16 = 1'b1;
      tick();                                   // accept
      inValid16 = 1'b0;
      tick();                                   // first nibble done
      check("midrun_busy", {31'd0, busy16}, 32'd1);
      reset = 1'b0;
      tick();
      check("midrun_reset", {13'd0, outValid16, busy16, cOut16, s16}, 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("midrun_noResult", {30'd0, outValid16, busy16}, 32'd0);
      end
      outReady16 = 1'b0;
      doOp16(16'h0001, 16'h0001, 1'b0, 1'b0, 0, "afterReset");

`ifdef ADDER_SEQ_SUB_EN
      doOp16(16'h0005, 16'h0007, 1'b0, 1'b1, 0, "subBorrow");
      doOp16(16'h0007, 16'h0005, 1'b1, 1'b1, 1, "subNoBorrow");
`endif

      // Randomized transactions
      for (int i = 0; i < 24; i++) begin
         doOp16(16'($urandom), 16'($urandom), 1'($urandom),
                SUB_EN ? 1'($urandom) : 1'b0, int'($urandom_range(0, 2)), "rand");
      end

      // Single-nibble build
      doOp4(4'h9, 4'h8, 1'b1, 1'b0, "w4");
      for (int i = 0; i < 6; i++) begin
         doOp4(4'($urandom), 4'($urandom), 1'($urandom),
               SUB_EN ? 1'($urandom) : 1'b0, "w4rand");
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
`default_nettype wire
